// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared constants and types for the timer/measurement blocks.
//   CLK_HZ          : system clock frequency (Hz)
//   TIMEOUT_DEFAULT : default no-edge timeout in clk cycles (2 s at CLK_HZ)
//   state_e         : measurement FSM states (IDLE, MEAS)
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned TIMEOUT_DEFAULT = 2 * CLK_HZ;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer for an asynchronous input, followed by a third
// registered copy used for edge detection. Edge strobes are registered so
// that sync, rise and fall are all aligned to the same clock cycle.
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (all flops cleared)
//   sig_in : asynchronous input
//   sync   : synchronized level, aligned with rise/fall
//   rise   : one-cycle strobe on a 0->1 transition of the synchronized input
//   fall   : one-cycle strobe on a 1->0 transition of the synchronized input
// -----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= sig_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
      fall_q <= ~sync_q & dly_q;
    end
  end

  // dly_q carries the level that rise_q/fall_q were derived from, so the
  // three outputs describe the same sample.
  assign sync = dly_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pulse_period_meter.sv
// -----------------------------------------------------------------------------
// pulse_period_meter
// Measures the period (rising edge to rising edge, in clk cycles) of an
// asynchronous pulse train. A measurement is reported with a one-cycle
// meas_valid pulse; the first rising edge after IDLE only arms the counter.
// If no rising edge is seen for TIMEOUT_CYC cycles the block returns to IDLE
// and raises timeout until the next measurement is reported.
//
// Optional feature (macro PULSE_PERIOD_METER_HIGH_TIME_EN): adds the
// high_time output, the number of cycles the synchronized input was high
// within the reported period.
//
// Parameters
//   TIMEOUT_CYC : no-edge timeout in clk cycles (must be < 2**CNT_W)
//   CNT_W       : width of the counters and measurement outputs
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   sig_in     : asynchronous pulse train
//   period     : cycles between the last two rising edges
//   high_time  : cycles high within the last period (feature macro only)
//   meas_valid : one-cycle pulse when period/high_time update
//   timeout    : level, no rising edge within TIMEOUT_CYC cycles
//   busy       : high while measuring (state MEAS)
// -----------------------------------------------------------------------------
module pulse_period_meter
  import timer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);

  logic rise;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  logic sync;
  logic fall;
`else
  logic sync_unused;
  logic fall_unused;
`endif

  sync_edge_det u_sync_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    .sync   (sync),
    .rise   (rise),
    .fall   (fall)
`else
    .sync   (sync_unused),
    .rise   (rise),
    .fall   (fall_unused)
`endif
  );

  // ---------------------------------------------------------------------------
  // Period measurement FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        // First edge only arms the counter; timeout stays until a report.
        if (rise) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
        end
      end
      MEAS: begin
        if (rise) begin
          // Report and restart in the same cycle: no dead cycle between
          // back-to-back periods.
          period_d  = cnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = CNT_ONE;
        end else if (cnt_q == CNT_TMO) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period     = period_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q == MEAS);

`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  // ---------------------------------------------------------------------------
  // High-time measurement
  // Counts synchronized-high cycles from the rising edge; the first falling
  // edge freezes the count. Without a falling edge the count tracks the
  // period counter, so high_time equals period.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             hi_run_q, hi_run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q   <= '0;
      high_q   <= '0;
      hi_run_q <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      high_q   <= high_d;
      hi_run_q <= hi_run_d;
    end
  end

  always_comb begin
    hcnt_d   = hcnt_q;
    high_d   = high_q;
    hi_run_d = hi_run_q;
    if (rise) begin
      if (state_q == MEAS) begin
        high_d = hcnt_q;
      end
      hcnt_d   = CNT_ONE;
      hi_run_d = 1'b1;
    end else if (state_q == MEAS) begin
      if (fall) begin
        hi_run_d = 1'b0;
      end else if (hi_run_q && sync) begin
        hcnt_d = hcnt_q + CNT_ONE;
      end
    end
  end

  assign high_time = high_q;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_period_meter
// Self-checking bench for pulse_period_meter (TIMEOUT_CYC = 5000). A
// timestamp-based reference model predicts every output on every cycle;
// directed phases pin the model with hand-computed values.
// Builds with or without PULSE_PERIOD_METER_HIGH_TIME_EN.
// -----------------------------------------------------------------------------
module tb_pulse_period_meter;

  localparam int unsigned TMO = 5000;
  localparam int unsigned CW  = 27;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period;
  logic          meas_valid;
  logic          timeout;
  logic          busy;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  logic [CW-1:0] high_time;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pulse_period_meter #(
    .TIMEOUT_CYC (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    .high_time  (high_time),
`endif
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. A rising edge of sig_in sampled at clock edge k becomes
  // visible on the outputs after edge k+3. Periods are differences between
  // the output-visible cycles of consecutive rising edges.
  // ---------------------------------------------------------------------------
  longint unsigned cyc = 0;
  logic [4:0]      hist = '0;      // hist[i] = sig_in sampled i edges ago
  logic            m_meas = 1'b0, m_valid = 1'b0, m_timeout = 1'b0, m_fell = 1'b0;
  longint unsigned m_last = 0, m_fall_c = 0, m_period = 0, m_high = 0;

  // Monitor results (actual DUT outputs, compared against literals later)
  int unsigned     mv_count = 0;
  longint unsigned rep_p[$];
  longint unsigned rep_h[$];
  longint unsigned last_mv_cyc = 0, to_rise_cyc = 0;
  logic            prev_to = 1'b0;

  always @(posedge clk) begin
    logic            ev_rise, ev_fall;
    longint unsigned act_h, exp_h;
    cyc++;
    m_valid = 1'b0;
    if (!rst_n) begin
      hist      = '0;
      m_meas    = 1'b0;
      m_timeout = 1'b0;
      m_fell    = 1'b0;
      m_period  = 0;
      m_high    = 0;
    end else begin
      hist    = {hist[3:0], sig_in};
      ev_rise = hist[3] & ~hist[4];
      ev_fall = ~hist[3] & hist[4];
      if (ev_rise) begin
        if (m_meas) begin
          m_period  = cyc - m_last;
          m_high    = m_fell ? (m_fall_c - m_last) : (cyc - m_last);
          m_valid   = 1'b1;
          m_timeout = 1'b0;
        end
        m_meas = 1'b1;
        m_last = cyc;
        m_fell = 1'b0;
      end else if (m_meas) begin
        if (ev_fall && !m_fell) begin
          m_fell   = 1'b1;
          m_fall_c = cyc;
        end
        if (cyc - m_last == TMO) begin
          m_meas    = 1'b0;
          m_timeout = 1'b1;
        end
      end
    end
    #1;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    act_h = longint'(high_time);
    exp_h = m_high;
`else
    act_h = 0;
    exp_h = 0;
`endif
    n_checks++;
    if (meas_valid !== m_valid || busy !== m_meas || timeout !== m_timeout ||
        longint'(period) !== m_period || act_h !== exp_h) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got valid=%0b busy=%0b timeout=%0b period=%0d high=%0d, expected valid=%0b busy=%0b timeout=%0b period=%0d high=%0d",
               cyc, meas_valid, busy, timeout, period, act_h,
               m_valid, m_meas, m_timeout, m_period, exp_h);
    end
    if (meas_valid === 1'b1) begin
      mv_count++;
      rep_p.push_back(longint'(period));
      rep_h.push_back(act_h);
      last_mv_cyc = cyc;
    end
    if (timeout === 1'b1 && !prev_to) to_rise_cyc = cyc;
    prev_to = timeout;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: called 2 time units after a rising clock edge.
  // ---------------------------------------------------------------------------
  task automatic hold(input logic v, input int unsigned n);
    sig_in = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic square(input int unsigned hi, input int unsigned lo, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  initial begin
    int unsigned base;
    int unsigned nrep;
    int unsigned k;
    int unsigned n_two;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_period",  longint'(period), 0);
    check("reset_flags",   {61'd0, meas_valid, busy, timeout}, 0);
    rst_n = 1'b1;
    hold(1'b0, 5);

    // Square wave 1000 / high 300: no report on first edge
    base = mv_count;
    nrep = rep_p.size();
    square(300, 700, 5);
    check("sq_pulses",  mv_count - base, 4);
    check("sq_period",  rep_p[$], 1000);
    check("model_sq",   m_period, 1000);
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    check("sq_high",    rep_h[$], 300);
    check("model_high", m_high, 300);
`endif

    // Period switch 1000 -> 250 without a dropped report
    nrep = rep_p.size();
    square(100, 150, 3);
    check("sw_count",  rep_p.size() - nrep, 3);
    check("sw_first",  rep_p[nrep], 1000);
    check("sw_second", rep_p[nrep+1], 250);
    check("sw_third",  rep_p[nrep+2], 250);
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    check("sw_high",   rep_h[nrep+1], 100);
`endif

    // Timeout after edges stop
    square(300, 700, 2);
    sig_in = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      if (timeout === 1'b1) break;
    end
    #1;
    check("to_level",  timeout, 1);
    check("to_busy",   busy, 0);
    check("to_period", longint'(period), 1000);
    check("to_delay",  to_rise_cyc - last_mv_cyc, TMO);
    base = mv_count;
    square(300, 700, 1);
    check("to_held_first_edge", timeout, 1);
    check("to_no_pulse",        mv_count - base, 0);
    square(300, 700, 1);
    check("to_cleared",   timeout, 0);
    check("to_report",    rep_p[$], 1000);

    // Reset mid-period
    hold(1'b1, 150);
    rst_n = 1'b0;
    hold(1'b1, 3);
    check("rst_period", longint'(period), 0);
    check("rst_flags",  {61'd0, meas_valid, busy, timeout}, 0);
    rst_n = 1'b1;
    base = mv_count;
    hold(1'b1, 147);
    check("rst_first_edge_no_pulse", mv_count - base, 0);
    check("rst_first_edge_busy",     busy, 1);
    hold(1'b0, 700);
    square(300, 700, 3);
    check("rst_pulses", mv_count - base, 3);

    // Minimum period: 1 high, 1 low
    nrep = rep_p.size();
    square(1, 1, 20);
    hold(1'b0, 6);
    n_two = 0;
    for (int unsigned i = nrep + 1; i < rep_p.size(); i++)
      if (rep_p[i] == 2) n_two++;
    check("min_reports", rep_p.size() - nrep, 20);
    check("min_period2", n_two, 19);
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    check("min_high",    rep_h[$], 1);
`endif

    // Latency from the first edge sampling sig_in high to meas_valid
    sig_in = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      k++;
      #1;
      if (meas_valid === 1'b1) break;
    end
    #1;
    check("latency", k - 1, 3);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Randomized pulse trains, including one gap beyond the timeout
    for (int i = 0; i < 30; i++) begin
      int unsigned hi, lo;
      hi = $urandom_range(1, 300);
      lo = (i == 15) ? TMO + 300 : $urandom_range(1, 300);
      square(hi, lo, 1);
    end
    hold(1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
